// File: rtl/dac_pkg.sv
// Shared types and DAC command-word layout for the galvo DAC point sequencer.
// The word format matches an MCP4822-style dual 12-bit DAC.
package dac_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StStartX,
        StWaitBusyX,
        StWaitDoneX,
        StGapX,
        StStartY,
        StWaitBusyY,
        StWaitDoneY,
        StGapY,
        StLdac
    } state_t;

    localparam int unsigned CH_BIT       = 15;
    localparam int unsigned GA_BIT       = 13;
    localparam int unsigned SHDN_BIT     = 12;
    localparam int unsigned CODE_BITS    = 12;
    localparam int unsigned SPI_WORD_LEN = 16;

    // shdn=1 clears the active-low SHDN bit so the DAC output is parked off.
    function automatic logic [15:0] build_dac_word(input logic ch, input logic shdn,
                                                   input logic [CODE_BITS-1:0] code);
        logic [15:0] word;
        word                  = 16'h0000;
        word[CH_BIT]          = ch;
        word[GA_BIT]          = 1'b1;
        word[SHDN_BIT]        = ~shdn;
        word[CODE_BITS-1:0]   = code;
        return word;
    endfunction

endpackage

// File: rtl/dac_point_sequencer.sv
// Takes one (x,y) point per handshake, sends channel A then channel B words through the
// shared SPI master, then pulses LDAC so both DAC outputs update together.
module dac_point_sequencer
    import dac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 12,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned LDAC_CYCLES   = 2,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic                  point_valid_in,
    output logic                  point_ready_out,
    input  logic                  shutdown_in,
    output logic [15:0]           spi_data_out,
    output logic [5:0]            spi_data_length_out,
    output logic                  spi_start_out,
    input  logic                  spi_busy_in,
    output logic                  ldac_out,
    output logic                  error_out,
    output logic [15:0]           points_sent_out
);

    localparam logic [15:0] TIMEOUT_LOAD = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] GAP_LOAD     = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] LDAC_LOAD    = 16'(LDAC_CYCLES - 1);

    state_t                state;
    logic [15:0]           cnt;
    logic [DATA_WIDTH-1:0] y_q;
    logic                  shdn_q;

    assign spi_data_length_out = 6'(SPI_WORD_LEN);

    // One down-counter is shared by the start timeout, the inter-word gap and the LDAC width.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state           <= StIdle;
            cnt             <= 16'h0000;
            y_q             <= '0;
            shdn_q          <= 1'b0;
            point_ready_out <= 1'b0;
            spi_data_out    <= 16'h0000;
            spi_start_out   <= 1'b0;
            ldac_out        <= 1'b1;
            error_out       <= 1'b0;
            points_sent_out <= 16'h0000;
        end else begin
            spi_start_out <= 1'b0;
            case (state)
                StIdle: begin
                    if (point_ready_out && point_valid_in) begin
                        y_q             <= y_in;
                        shdn_q          <= shutdown_in;
                        spi_data_out    <= build_dac_word(1'b0, shutdown_in, CODE_BITS'(x_in));
                        spi_start_out   <= 1'b1;
                        point_ready_out <= 1'b0;
                        state           <= StStartX;
                    end else begin
                        point_ready_out <= 1'b1;
                    end
                end
                StStartX: begin
                    cnt   <= TIMEOUT_LOAD;
                    state <= StWaitBusyX;
                end
                StWaitBusyX: begin
                    if (spi_busy_in) begin
                        state <= StWaitDoneX;
                    end else if (cnt == 16'h0000) begin
                        error_out <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        cnt <= cnt - 16'h0001;
                    end
                end
                StWaitDoneX: begin
                    if (!spi_busy_in) begin
                        cnt   <= GAP_LOAD;
                        state <= StGapX;
                    end
                end
                StGapX: begin
                    if (cnt == 16'h0000) begin
                        spi_data_out  <= build_dac_word(1'b1, shdn_q, CODE_BITS'(y_q));
                        spi_start_out <= 1'b1;
                        state         <= StStartY;
                    end else begin
                        cnt <= cnt - 16'h0001;
                    end
                end
                StStartY: begin
                    cnt   <= TIMEOUT_LOAD;
                    state <= StWaitBusyY;
                end
                StWaitBusyY: begin
                    if (spi_busy_in) begin
                        state <= StWaitDoneY;
                    end else if (cnt == 16'h0000) begin
                        error_out <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        cnt <= cnt - 16'h0001;
                    end
                end
                StWaitDoneY: begin
                    if (!spi_busy_in) begin
                        cnt   <= GAP_LOAD;
                        state <= StGapY;
                    end
                end
                StGapY: begin
                    if (cnt == 16'h0000) begin
                        ldac_out <= 1'b0;
                        cnt      <= LDAC_LOAD;
                        state    <= StLdac;
                    end else begin
                        cnt <= cnt - 16'h0001;
                    end
                end
                StLdac: begin
                    if (cnt == 16'h0000) begin
                        ldac_out        <= 1'b1;
                        points_sent_out <= points_sent_out + 16'h0001;
                        state           <= StIdle;
                    end else begin
                        cnt <= cnt - 16'h0001;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_point_sequencer.sv
// Self-checking bench for dac_point_sequencer with a behavioural SPI busy model.
module tb_dac_point_sequencer;

    localparam int GAP     = 4;
    localparam int LDACW   = 2;
    localparam int TMO     = 8;
    localparam int SPI_LEN = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] x = '0, y = '0;
    logic        valid = 1'b0, shdn = 1'b0;
    logic        ready, start, ldac, err;
    logic [15:0] data, pts;
    logic [5:0]  len;
    logic        busy = 1'b0;
    bit          stub = 1'b0;

    int n_checks = 0, n_fail = 0;
    logic [15:0] exp_q[$];

    // Monitor-owned state (written only by the monitor block)
    logic [15:0] obs_w [0:255];
    int          obs_wr = 0;
    int          ldac_w [0:255];
    int          ldac_wr = 0;
    int          mon_viol = 0, gap_checks = 0, stab_checks = 0;
    int          start_cyc = 0, idle_cnt = 0, ldac_low = 0;
    logic [15:0] cap = '0;
    logic        prev_busy = 1'b0, had_word = 1'b0;

    // Bench-owned read pointers
    int obs_rd = 0, ldac_rd = 0;
    int cyc = 0, spi_cnt = 0;

    dac_point_sequencer #(
        .DATA_WIDTH(12), .GAP_CYCLES(GAP), .LDAC_CYCLES(LDACW), .START_TIMEOUT(TMO)
    ) dut (
        .clock_in(clk), .reset_in(rst), .x_in(x), .y_in(y),
        .point_valid_in(valid), .point_ready_out(ready), .shutdown_in(shdn),
        .spi_data_out(data), .spi_data_length_out(len), .spi_start_out(start),
        .spi_busy_in(busy), .ldac_out(ldac), .error_out(err), .points_sent_out(pts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master stand-in: busy for SPI_LEN cycles after a start pulse unless stubbed.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            spi_cnt <= 0;
        end else if (busy) begin
            if (spi_cnt == 0) busy <= 1'b0;
            else spi_cnt <= spi_cnt - 1;
        end else if (start && !stub) begin
            busy    <= 1'b1;
            spi_cnt <= SPI_LEN - 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            had_word  <= 1'b0;
            prev_busy <= 1'b0;
            idle_cnt  <= 0;
            ldac_low  <= 0;
        end else begin
            if (start) begin
                if (busy) begin
                    mon_viol <= mon_viol + 1;
                    $display("FAIL start_while_busy: start=1 with busy=1, required busy=0");
                end
                cap                 <= data;
                obs_w[obs_wr[7:0]]  <= data;
                obs_wr              <= obs_wr + 1;
                start_cyc           <= cyc;
            end
            if (busy) begin
                stab_checks <= stab_checks + 1;
                if (data !== cap) begin
                    mon_viol <= mon_viol + 1;
                    $display("FAIL data_stable: data=%h required %h", data, cap);
                end
            end
            if (busy && !prev_busy && had_word) begin
                gap_checks <= gap_checks + 1;
                if (idle_cnt < GAP) begin
                    mon_viol <= mon_viol + 1;
                    $display("FAIL cs_gap: gap=%0d required >=%0d", idle_cnt, GAP);
                end
            end
            if (!busy && prev_busy) had_word <= 1'b1;
            idle_cnt <= busy ? 0 : idle_cnt + 1;
            if (ready && (busy || !ldac)) begin
                mon_viol <= mon_viol + 1;
                $display("FAIL ready_idle: ready=1 while busy=%b ldac=%b", busy, ldac);
            end
            if (!ldac) begin
                ldac_low <= ldac_low + 1;
            end else begin
                ldac_low <= 0;
                if (ldac_low > 0) begin
                    ldac_w[ldac_wr[7:0]] <= ldac_low;
                    ldac_wr              <= ldac_wr + 1;
                end
            end
            prev_busy <= busy;
        end
    end

    function automatic logic [15:0] model_word(input bit ch, input bit sd, input logic [11:0] c);
        return {ch, 1'b0, 1'b1, ~sd, c};
    endfunction

    task automatic send_point(input logic [11:0] px, input logic [11:0] py, input logic psd,
                              input bit hold_after);
        bit ok;
        exp_q.push_back(model_word(1'b0, psd, px));
        exp_q.push_back(model_word(1'b1, psd, py));
        @(negedge clk);
        x = px; y = py; shdn = psd; valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!hold_after) valid = 1'b0;
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL accept: ready not seen within bound, got %b required 1", ok);
        end
    endtask

    task automatic wait_points(input logic [15:0] target);
        for (int i = 0; i < 3000 && pts !== target; i++) @(negedge clk);
        n_checks++;
        if (pts !== target) begin
            n_fail++;
            $display("FAIL points_sent: got %0d required %0d", pts, target);
        end
    endtask

    task automatic check_words();
        logic [15:0] e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_wr) begin
                n_fail++;
                $display("FAIL spi_word: no word captured, required %h", e);
            end else begin
                if (obs_w[obs_rd[7:0]] !== e) begin
                    n_fail++;
                    $display("FAIL spi_word: got %h required %h", obs_w[obs_rd[7:0]], e);
                end
                obs_rd++;
            end
        end
        n_checks++;
        if (obs_rd !== obs_wr) begin
            n_fail++;
            $display("FAIL extra_words: got %0d unexpected words required 0", obs_wr - obs_rd);
        end
    endtask

    task automatic check_ldac(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (ldac_rd >= ldac_wr) begin
                n_fail++;
                $display("FAIL ldac_pulse: missing pulse, required width %0d", LDACW);
            end else begin
                if (ldac_w[ldac_rd[7:0]] !== LDACW) begin
                    n_fail++;
                    $display("FAIL ldac_width: got %0d required %0d", ldac_w[ldac_rd[7:0]], LDACW);
                end
                ldac_rd++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", ready); end
        if (data !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", data); end
        if (start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b required 0", start); end
        if (ldac !== 1'b1) begin n_fail++; $display("FAIL rst_ldac: got %b required 1", ldac); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b required 0", err); end
        if (pts !== 16'h0) begin n_fail++; $display("FAIL rst_points: got %0d required 0", pts); end
        if (len !== 6'd16) begin n_fail++; $display("FAIL data_length: got %0d required 16", len); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", ready); end
    endtask

    task automatic test_single();
        send_point(12'h123, 12'hABC, 1'b0, 1'b0);
        wait_points(16'd1);
        check_words();
        check_ldac(1);
    endtask

    task automatic test_shutdown();
        send_point(12'hFFF, 12'hA55, 1'b1, 1'b0);
        wait_points(16'd2);
        check_words();
        check_ldac(1);
    endtask

    task automatic test_back_to_back();
        send_point(12'h001, 12'h800, 1'b0, 1'b1);
        send_point(12'h7FE, 12'h3C3, 1'b0, 1'b1);
        send_point(12'hF0F, 12'h000, 1'b0, 1'b0);
        wait_points(16'd5);
        check_words();
        check_ldac(3);
    endtask

    task automatic test_reset_mid();
        send_point(12'h456, 12'h789, 1'b0, 1'b0);
        for (int i = 0; i < 400 && (obs_wr - obs_rd) < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_y_busy: got %b required 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_checks += 5;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b required 0", ready); end
        if (data !== 16'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h required 0", data); end
        if (start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_start: got %b required 0", start); end
        if (ldac !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ldac: got %b required 1", ldac); end
        if (pts !== 16'h0) begin n_fail++; $display("FAIL mid_rst_points: got %0d required 0", pts); end
        repeat (2) @(negedge clk);
        exp_q.delete();
        obs_rd  = obs_wr;
        ldac_rd = ldac_wr;
        rst     = 1'b0;
        send_point(12'h5A5, 12'h0F0, 1'b0, 1'b0);
        wait_points(16'd1);
        check_words();
        check_ldac(1);
    endtask

    task automatic test_timeout();
        int elapsed;
        logic [15:0] e;
        bit rdy;
        stub = 1'b1;
        send_point(12'h321, 12'h654, 1'b0, 1'b0);
        for (int i = 0; i < 100 && err !== 1'b1; i++) @(negedge clk);
        elapsed = cyc - start_cyc;
        n_checks += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b required 1", err); end
        if (elapsed < TMO || elapsed > TMO + 2) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", elapsed, TMO, TMO + 2);
        end
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin rdy = 1'b1; break; end
        end
        e = exp_q.pop_front();
        exp_q.delete();
        n_checks += 4;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got %b required 1", rdy); end
        if (pts !== 16'd1) begin n_fail++; $display("FAIL timeout_points: got %0d required 1", pts); end
        if (ldac_wr !== ldac_rd) begin
            n_fail++;
            $display("FAIL timeout_ldac: got %0d pulses required 0", ldac_wr - ldac_rd);
        end
        if (obs_w[obs_rd[7:0]] !== e) begin
            n_fail++;
            $display("FAIL timeout_word: got %h required %h", obs_w[obs_rd[7:0]], e);
        end
        obs_rd = obs_wr;
        stub = 1'b0;
        send_point(12'h0AA, 12'h155, 1'b0, 1'b0);
        wait_points(16'd2);
        check_words();
        check_ldac(1);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b required 1", err); end
    endtask

    task automatic test_protocol();
        n_checks += 3;
        if (mon_viol !== 0) begin n_fail++; $display("FAIL protocol: got %0d violations required 0", mon_viol); end
        if (gap_checks < 1) begin n_fail++; $display("FAIL gap_coverage: got %0d required >0", gap_checks); end
        if (stab_checks < 1) begin n_fail++; $display("FAIL stable_coverage: got %0d required >0", stab_checks); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_shutdown();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
